pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage CPU (IF/ID/EX/MEM/WB).
//  Takes the ID-stage load-use stall and JAL redirect, the EX branch redirect and the MEM data-memory handshake.
//  Produces the PC write enable, the PC source select, and a write-enable/flush pair for each pipeline register.
//  Holds a small FSM that freezes the pipe during multi-cycle memory accesses and halts on bus timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in S_MEM_WAIT before S_ERR (legal range 2..255)
//  CNT_W        32  width of performance counters (only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk             in   1   single system clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  id_stall        in   1   load-use hazard detected in ID
//  id_branch_flag  in   1   JAL redirect resolved in ID
//  ex_branch_flag  in   1   conditional branch / JALR redirect resolved in EX
//  if_ready        in   1   instruction fetch data valid this cycle
//  mem_req         in   1   MEM stage holds a load/store
//  mem_ready       in   1   data memory completes the access this cycle
//  pc_we           out  1   PC register update
//  pc_sel          out  2   next-PC source: `PC_SEL_SEQ / `PC_SEL_ID / `PC_SEL_EX
//  ifid_we         out  1   IF/ID load enable (paired with ifid_flush)
//  ifid_flush      out  1   IF/ID bubble insert
//  idex_we         out  1   ID/EX load enable (paired with idex_flush)
//  idex_flush      out  1   ID/EX bubble insert
//  exmem_we        out  1   EX/MEM load enable
//  memwb_we        out  1   MEM/WB load enable (paired with memwb_flush)
//  memwb_flush     out  1   MEM/WB bubble insert
//  halt            out  1   sticky bus-timeout indication
//  perf_stall_cnt  out  CNT_W  load-use stall cycles (macro only)
//  perf_flush_cnt  out  CNT_W  redirect events (macro only)
// BEHAVIOUR
//  Outputs are combinational from the registered state and the current inputs.
//  flush overrides we on the same register.
//  While rst=1:
//   - all *_we=0, all *_flush=1, pc_sel=SEQ, halt=0.
//   - On the next edge: state=S_RUN, timeout counter=0, perf counters=0.
//   - A reset asserted in S_MEM_WAIT or S_ERR goes straight to S_RUN.
//  S_RUN priority (highest first):
//   1. mem_req & !mem_ready: all we=0, memwb_flush=1, pc_we=0. Next state S_MEM_WAIT, tcnt=1.
//   2. ex_branch_flag: pc_we=1, pc_sel=EX, ifid_flush=1, idex_flush=1. exmem/memwb advance.
//   3. id_stall: pc_we=0, ifid_we=0, idex_flush=1. exmem/memwb advance.
//      An ID redirect asserted together with id_stall is ignored and re-evaluated next cycle.
//   4. id_branch_flag: pc_we=1, pc_sel=ID, ifid_flush=1. All other registers advance.
//   5. !if_ready: pc_we=0, ifid_flush=1. All other registers advance.
//   6. Otherwise: all we=1, no flush, pc_sel=SEQ.
//  S_MEM_WAIT:
//   - Outputs are the same as rule 1 (full freeze, bubble into WB).
//   - mem_ready=1: drive S_RUN rules 2..6 this cycle (the access completes). Next state S_RUN.
//   - Else if tcnt==MEM_TIMEOUT-1: next state S_ERR.
//   - Else tcnt+1.
//  S_ERR: all we=0, all flush=1, halt=1. Left only by rst.
//  An ID/EX redirect raised during S_MEM_WAIT is held by the frozen stages and acts on the release cycle.
//  The memory-stall path adds no extra latency: the release cycle advances the pipe.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//   - perf_stall_cnt +1 on every cycle rule 3 fires.
//   - perf_flush_cnt +1 on every cycle rule 2 or 4 fires.
//   - Both counters saturate at all-ones.
//  PIPE_CTRL_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.
// STRUCTURE
//  Add to ctrl_encode_def.vh:
//   - `PC_SEL_SEQ=2'b00, `PC_SEL_ID=2'b01, `PC_SEL_EX=2'b10
//   - `S_RUN=2'd0, `S_MEM_WAIT=2'd1, `S_ERR=2'd2
//  Sub-module pipe_perf_cnt (saturating CNT_W counter) is instantiated twice, only under PIPE_CTRL_PERF_EN.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> all we=0, all flush=1, halt=0. After release with no events -> all we=1, pc_sel=00.
//  2. Load-use: id_stall=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1. Next cycle normal.
//     With PIPE_CTRL_PERF_EN, perf_stall_cnt=1.
//  3. Redirect: ex_branch_flag=1 & id_branch_flag=1 & id_stall=1 -> pc_sel=10, ifid_flush=1, idex_flush=1.
//     id_branch_flag=1 alone -> pc_sel=01, ifid_flush=1, idex_we=1.
//  4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_flush=1,
//     then a release cycle with all we=1, then S_RUN.
//  5. Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 -> halt=1 on the 5th cycle after the request.
//     It stays high; rst clears it in 1 cycle.
//  6. Reset mid-wait: rst during cycle 2 of S_MEM_WAIT -> S_RUN after release, tcnt=0, no halt.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, next-PC select codes
// and the bundle of per-register write-enable/flush controls.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_ID  = 2'b01;
    localparam logic [1:0] PC_SEL_EX  = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ifid_we;
        logic       ifid_flush;
        logic       idex_we;
        logic       idex_flush;
        logic       exmem_we;
        logic       memwb_we;
        logic       memwb_flush;
    } ctrl_t;

    // Every register held, every bubble inserted: used in reset and on halt.
    function automatic ctrl_t ctrl_kill();
        ctrl_t c;
        c = '{pc_we: 1'b0, pc_sel: PC_SEL_SEQ, ifid_we: 1'b0, ifid_flush: 1'b1,
              idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0, memwb_we: 1'b0,
              memwb_flush: 1'b1};
        return c;
    endfunction

    // Whole pipe frozen behind an outstanding data access; WB receives a bubble.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c = '{pc_we: 1'b0, pc_sel: PC_SEL_SEQ, ifid_we: 1'b0, ifid_flush: 1'b0,
              idex_we: 1'b0, idex_flush: 1'b0, exmem_we: 1'b0, memwb_we: 1'b0,
              memwb_flush: 1'b1};
        return c;
    endfunction

    // Hazard/redirect resolution once memory is not blocking, highest priority first.
    // A flushed register also has its load enable dropped.
    function automatic ctrl_t ctrl_run(input logic ex_br, input logic stall,
                                       input logic id_br, input logic fetch_ok);
        ctrl_t c;
        c = '{pc_we: 1'b1, pc_sel: PC_SEL_SEQ, ifid_we: 1'b1, ifid_flush: 1'b0,
              idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1, memwb_we: 1'b1,
              memwb_flush: 1'b0};
        if (ex_br) begin
            c.pc_sel     = PC_SEL_EX;
            c.ifid_we    = 1'b0;
            c.ifid_flush = 1'b1;
            c.idex_we    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (stall) begin
            // A JAL seen alongside the stall is dropped; it is re-presented next cycle.
            c.pc_we      = 1'b0;
            c.ifid_we    = 1'b0;
            c.idex_we    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (id_br) begin
            c.pc_sel     = PC_SEL_ID;
            c.ifid_we    = 1'b0;
            c.ifid_flush = 1'b1;
        end else if (!fetch_ok) begin
            c.pc_we      = 1'b0;
            c.ifid_we    = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter for pipeline performance statistics.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC/pipeline-register controls,
// memory-wait freeze and bus-timeout halt. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             id_branch_flag,
    input  logic             ex_branch_flag,
    input  logic             if_ready,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam logic [7:0] TCNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] tcnt;
    ctrl_t      ctrl;
    logic       mem_block;
    logic       run_active;

    assign mem_block = mem_req && !mem_ready;

    // Rules 2..6 are evaluated in S_RUN when memory is not blocking, and on the
    // release cycle of S_MEM_WAIT so the completing access costs no extra cycle.
    assign run_active = !rst && (((state == S_RUN) && !mem_block) ||
                                 ((state == S_MEM_WAIT) && mem_ready));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        ctrl = ctrl_kill();
        halt = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN, S_MEM_WAIT: begin
                    if (run_active) ctrl = ctrl_run(ex_branch_flag, id_stall, id_branch_flag, if_ready);
                    else            ctrl = ctrl_freeze();
                end
                S_ERR:   halt = 1'b1;
                default: ctrl = ctrl_kill();
            endcase
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign pc_sel      = ctrl.pc_sel;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_we     = ctrl.idex_we;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_we    = ctrl.exmem_we;
    assign memwb_we    = ctrl.memwb_we;
    assign memwb_flush = ctrl.memwb_flush;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            tcnt  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_block) begin
                        state <= S_MEM_WAIT;
                        tcnt  <= 8'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= S_RUN;
                        tcnt  <= '0;
                    end else if (tcnt == TCNT_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_fire;
    logic flush_fire;

    assign stall_fire = run_active && !ex_branch_flag && id_stall;
    assign flush_fire = run_active && (ex_branch_flag || (!id_stall && id_branch_flag));

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_fire),
        .cnt (perf_stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_fire),
        .cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
